// File: rtl/rv_pipe_pkg.sv
// Shared types for the RV pipeline front end.
//   NOP_INSTR     : bubble encoding (addi x0,x0,0)
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : one buffered instruction word with its address
package rv_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched instruction words until decode takes them.
// Ports:
//   clk, reset (async, active-low)
//   push, wr_data : enqueue one entry (accepted when not full, or when full and popping)
//   pop           : dequeue the head (ignored when empty)
//   clear         : drop all entries; wins over push
//   head          : current head entry
//   empty, full, count : occupancy
module fetch_buffer import rv_pipe_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t wr_data,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding request
// at a time to instruction memory, buffers returned words and presents a
// registered instruction/PC pair to decode.
// Ports:
//   clk, reset (async, active-low)
//   StallF, FlushD        : hold / bubble the decode-facing register
//   PCSrc, PCTarget       : redirect from execute
//   imem_req, imem_addr   : request to instruction memory
//   imem_gnt              : request accepted this cycle
//   imem_rvalid, imem_rdata : response
//   Instr, PC, PC_plus_4, InstrValid : decode-facing register
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        FlushD,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4,
  output logic        InstrValid
);
  import rv_pipe_pkg::*;

  fetch_state_t state, state_n;
  logic [31:0]  fetch_pc, fetch_pc_n;
  logic [31:0]  req_pc;
  logic [31:0]  pending_pc;
  logic         pending_redirect, pending_n;

  fetch_entry_t buf_head;
  fetch_entry_t buf_wr;
  logic         buf_empty, buf_full;
  logic [1:0]   buf_count;
  logic         buf_push, buf_pop;

  logic room, issue, granted, resp, take_buf, take_resp;

  // Nothing is in flight while in FETCH, so room depends only on occupancy.
  assign room      = !buf_full && (int'(buf_count) < BUF_DEPTH);
  assign issue     = reset && (state == FETCH) && room;
  assign granted   = issue && imem_gnt;
  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  // A response is kept only if it belongs to a live request and no redirect
  // arrives with it.
  assign resp      = (state == WAIT) && imem_rvalid && !PCSrc;

  // A redirect empties the buffer, so decode sees nothing to take that cycle.
  assign take_buf  = !FlushD && !StallF && !PCSrc && !buf_empty;
  // With an empty buffer the arriving word goes straight into the decode
  // register, registered on the rvalid edge.
  assign take_resp = !FlushD && !StallF && buf_empty && resp;
  assign buf_pop   = take_buf;
  assign buf_push  = resp && !take_resp;
  assign buf_wr    = '{instr: imem_rdata, pc: req_pc};

  fetch_buffer u_buf (
    .clk     (clk),
    .reset   (reset),
    .push    (buf_push),
    .wr_data (buf_wr),
    .pop     (buf_pop),
    .clear   (PCSrc),
    .head    (buf_head),
    .empty   (buf_empty),
    .full    (buf_full),
    .count   (buf_count)
  );

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    pending_n  = pending_redirect;
    case (state)
      FETCH: begin
        if (granted) begin
          pending_n = 1'b0;
          if (PCSrc) begin
            fetch_pc_n = PCTarget;
            state_n    = DISCARD;
          end else if (pending_redirect) begin
            fetch_pc_n = pending_pc;
            state_n    = DISCARD;
          end else begin
            fetch_pc_n = fetch_pc + 32'd4;
            state_n    = WAIT;
          end
        end else if (PCSrc) begin
          // A raised request must keep its address until granted, so the
          // redirect is parked and applied at the grant.
          if (issue) pending_n  = 1'b1;
          else       fetch_pc_n = PCTarget;
        end
      end
      WAIT: begin
        if (PCSrc) begin
          fetch_pc_n = PCTarget;
          state_n    = imem_rvalid ? FETCH : DISCARD;
        end else if (imem_rvalid) begin
          state_n = FETCH;
        end
      end
      DISCARD: begin
        if (PCSrc)       fetch_pc_n = PCTarget;
        if (imem_rvalid) state_n    = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= FETCH;
      fetch_pc         <= RESET_PC;
      pending_redirect <= 1'b0;
    end else begin
      state            <= state_n;
      fetch_pc         <= fetch_pc_n;
      pending_redirect <= pending_n;
    end
  end

  always_ff @(posedge clk) begin
    if (granted) req_pc <= fetch_pc;
    if (issue && !imem_gnt && PCSrc) pending_pc <= PCTarget;
  end

  // Decode-facing register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Instr      <= NOP_INSTR;
      PC         <= 32'd0;
      PC_plus_4  <= 32'd0;
      InstrValid <= 1'b0;
    end else if (FlushD) begin
      Instr      <= NOP_INSTR;
      InstrValid <= 1'b0;
    end else if (!StallF) begin
      if (take_buf) begin
        Instr      <= buf_head.instr;
        PC         <= buf_head.pc;
        PC_plus_4  <= buf_head.pc + 32'd4;
        InstrValid <= 1'b1;
      end else if (take_resp) begin
        Instr      <= imem_rdata;
        PC         <= req_pc;
        PC_plus_4  <= req_pc + 32'd4;
        InstrValid <= 1'b1;
      end else begin
        Instr      <= NOP_INSTR;
        InstrValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        StallF, FlushD, PCSrc;
  logic [31:0] PCTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instr, PC, PC_plus_4;
  logic        InstrValid;

  fetch_stage dut (
    .clk(clk), .reset(reset), .StallF(StallF), .FlushD(FlushD),
    .PCSrc(PCSrc), .PCTarget(PCTarget), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .Instr(Instr), .PC(PC), .PC_plus_4(PC_plus_4),
    .InstrValid(InstrValid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  // Reference model: next fetch address, outstanding request (0 none,
  // 1 live, 2 stale), parked redirect, queue of fetched words, decode view.
  logic [31:0] m_pc, m_out_addr, m_pend_pc;
  int          m_out;
  bit          m_pend;
  entry_t      mq[$];
  logic [31:0] m_instr, m_pc_out, m_pc4;
  logic        m_valid;

  // Memory environment
  int          gnt_pct, min_d, max_d;
  bit          resp_busy;
  logic [31:0] resp_addr;
  int          resp_wait;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  function automatic bit model_req();
    return (reset === 1'b1) && (m_out == 0) && (mq.size() < 2);
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_out = 0; m_pend = 0; mq.delete();
    m_instr = NOP; m_pc_out = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit gnt, input bit rvalid, input logic [31:0] rdata,
                            input bit stall, input bit flush, input bit pcsrc,
                            input logic [31:0] target);
    bit     req, granted, accepted, used;
    entry_t e, h;
    req      = model_req();
    granted  = req && gnt;
    accepted = (m_out == 1) && rvalid && !pcsrc;
    e.instr  = rdata;
    e.pc     = m_out_addr;
    used     = 0;
    if (flush) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (!stall) begin
      if (!pcsrc && mq.size() > 0) begin
        h = mq.pop_front();
        m_instr = h.instr; m_pc_out = h.pc; m_pc4 = h.pc + 32'd4; m_valid = 1'b1;
      end else if (accepted) begin
        m_instr = e.instr; m_pc_out = e.pc; m_pc4 = e.pc + 32'd4; m_valid = 1'b1;
        used = 1;
      end else begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end
    if (pcsrc) mq.delete();
    else if (accepted && !used) mq.push_back(e);
    checks++;
    assert (mq.size() <= 2) else begin
      errors++;
      $error("FAIL buffer_overflow observed=%0d expected<=2", mq.size());
    end
    if (m_out != 0) begin
      if (pcsrc) m_pc = target;
      if (rvalid) m_out = 0;
      else if (pcsrc) m_out = 2;
    end else if (granted) begin
      m_out_addr = m_pc;
      if (pcsrc) begin
        m_pc = target; m_out = 2; m_pend = 0;
      end else if (m_pend) begin
        m_pc = m_pend_pc; m_out = 2; m_pend = 0;
      end else begin
        m_pc = m_pc + 32'd4; m_out = 1;
      end
    end else if (pcsrc) begin
      if (req) begin m_pend = 1; m_pend_pc = target; end
      else m_pc = target;
    end
  endtask

  // Entered near a falling edge: compare, drive the next cycle, advance model.
  task automatic cycle(input bit stall, input bit flush, input bit pcsrc,
                       input logic [31:0] target);
    bit          g, rv;
    logic [31:0] rd;
    chk1 ("imem_req",   imem_req,   model_req());
    chk32("imem_addr",  imem_addr,  m_pc);
    chk32("Instr",      Instr,      m_instr);
    chk32("PC",         PC,         m_pc_out);
    chk32("PC_plus_4",  PC_plus_4,  m_pc4);
    chk1 ("InstrValid", InstrValid, m_valid);
    rv = 0;
    rd = $urandom;
    if (resp_busy) begin
      if (resp_wait == 0) begin
        rv = 1; rd = mem_word(resp_addr); resp_busy = 0;
      end else begin
        resp_wait--;
      end
    end
    g = ($urandom_range(0, 99) < gnt_pct);
    if (model_req() && g) begin
      resp_busy = 1;
      resp_addr = m_pc;
      resp_wait = min_d + $urandom_range(0, max_d - min_d);
    end
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    StallF = stall; FlushD = flush; PCSrc = pcsrc; PCTarget = target;
    if (reset === 1'b1) model_step(g, rv, rd, stall, flush, pcsrc, target);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] old_addr, t;
    entry_t      h;
    int          n;

    reset = 1'b0; StallF = 0; FlushD = 0; PCSrc = 0; PCTarget = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    resp_busy = 0; resp_wait = 0; resp_addr = 0;
    gnt_pct = 100; min_d = 0; max_d = 0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state held, then release; 1-cycle memory
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    reset = 1'b1;
    #1;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk32("t1_instr", Instr, 32'h0050_0093);
    chk32("t1_pc", PC, 32'd0);
    chk32("t1_pc4", PC_plus_4, 32'd4);
    chk1 ("t1_valid", InstrValid, 1'b1);
    chk32("t1_next_addr", imem_addr, 32'd4);

    // Stall with the buffer filling up
    repeat (7) cycle(1, 0, 0, 0);
    chk1 ("t2_req_full", imem_req, 1'b0);
    chk32("t2_instr_hold", Instr, 32'h0050_0093);
    chk32("t2_pc_hold", PC, 32'd0);
    cycle(0, 0, 0, 0);
    chk32("t2_pc_first", PC, 32'd4);
    cycle(0, 0, 0, 0);
    chk32("t2_pc_second", PC, 32'd8);

    // Redirect while waiting for a response
    min_d = 1; max_d = 1;
    n = 0;
    while (m_out != 1 && n < 20) begin cycle(0, 0, 0, 0); n++; end
    chk1("t3_reach_wait", (m_out == 1), 1'b1);
    cycle(0, 0, 1, 32'h100);
    n = 0;
    while (!model_req() && n < 20) begin cycle(0, 0, 0, 0); n++; end
    chk32("t3_redirect_addr", imem_addr, 32'h100);
    n = 0;
    while (m_valid !== 1'b1 && n < 20) begin cycle(0, 0, 0, 0); n++; end
    chk32("t3_first_pc", PC, 32'h100);

    // Redirect while a request is held ungranted
    min_d = 0; max_d = 0; gnt_pct = 0;
    n = 0;
    while (!(model_req() && m_out == 0) && n < 20) begin cycle(0, 0, 0, 0); n++; end
    old_addr = m_pc;
    cycle(0, 0, 1, 32'h200);
    cycle(0, 0, 0, 0);
    chk1 ("t4_req_held", imem_req, 1'b1);
    chk32("t4_addr_held", imem_addr, old_addr);
    gnt_pct = 100;
    cycle(0, 0, 0, 0);
    n = 0;
    while (!model_req() && n < 20) begin cycle(0, 0, 0, 0); n++; end
    chk32("t4_target_addr", imem_addr, 32'h200);
    n = 0;
    while (m_valid !== 1'b1 && n < 20) begin cycle(0, 0, 0, 0); n++; end
    chk32("t4_first_pc", PC, 32'h200);

    // Flush together with stall, buffer holding entries
    repeat (6) cycle(1, 0, 0, 0);
    chk1("t5_buf_nonempty", (mq.size() > 0), 1'b1);
    h = mq[0];
    cycle(1, 1, 0, 0);
    chk32("t5_flush_instr", Instr, NOP);
    chk1 ("t5_flush_valid", InstrValid, 1'b0);
    cycle(0, 0, 0, 0);
    chk1 ("t5_head_valid", InstrValid, 1'b1);
    chk32("t5_head_pc", PC, h.pc);
    chk32("t5_head_instr", Instr, h.instr);

    // Address wrap at the top of memory
    cycle(0, 0, 1, 32'hFFFF_FFF8);
    n = 0;
    while (!(m_valid === 1'b1 && m_pc_out == 32'hFFFF_FFFC) && n < 30) begin
      cycle(0, 0, 0, 0); n++;
    end
    chk32("wrap_pc4", PC_plus_4, 32'd0);
    chk32("wrap_pc", PC, 32'hFFFF_FFFC);

    // Asynchronous reset while waiting; the late response must be ignored
    min_d = 3; max_d = 3;
    n = 0;
    while (m_out != 1 && n < 20) begin cycle(0, 0, 0, 0); n++; end
    chk1("t6_reach_wait", (m_out == 1), 1'b1);
    #2 reset = 1'b0;
    #1;
    chk32("t6_async_instr", Instr, NOP);
    chk32("t6_async_pc", PC, 32'd0);
    chk32("t6_async_pc4", PC_plus_4, 32'd0);
    chk1 ("t6_async_valid", InstrValid, 1'b0);
    chk1 ("t6_async_req", imem_req, 1'b0);
    model_reset();
    @(negedge clk);
    cycle(0, 0, 0, 0);
    reset = 1'b1;
    #1;
    gnt_pct = 0;
    repeat (5) cycle(0, 0, 0, 0);
    chk1("t6_late_gone", resp_busy, 1'b0);
    chk1("t6_still_bubble", InstrValid, 1'b0);
    gnt_pct = 100; min_d = 0; max_d = 0;
    n = 0;
    while (m_valid !== 1'b1 && n < 20) begin cycle(0, 0, 0, 0); n++; end
    chk32("t6_restart_pc", PC, 32'd0);
    chk32("t6_restart_instr", Instr, 32'h0050_0093);

    // Randomized traffic against the model
    gnt_pct = 60; min_d = 0; max_d = 2;
    repeat (400) begin
      t = $urandom;
      t[1:0] = 2'b00;
      cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 5, t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
